// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1/2 stop bits.
// The divider's baud square wave is synchronised and rising-edge detected, never used as a clock.
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_bps,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD  = (PARITY == 1);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PAR, STOP} state_t;

  state_t     state_q, state_d;
  logic       s1_q, s2_q, s3_q;
  logic       bps_tick;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       tx_q, tx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_bps;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign bps_tick = s2_q & ~s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_done = 1'b0;
    unique case (state_q)
      IDLE: if (tx_valid) begin
        shift_d = tx_data;
        par_d   = ^tx_data;
        state_d = ARM;
      end
      ARM:   if (bps_tick) state_d = START;
      START: if (bps_tick) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: if (bps_tick) begin
        shift_d = {1'b0, shift_q[7:1]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = PAR_EN ? PAR : STOP;
          stop_d  = 1'b0;
        end
      end
      PAR: if (bps_tick) begin
        state_d = STOP;
        stop_d  = 1'b0;
      end
      STOP: if (bps_tick) begin
        if (!TWO_STOP || stop_q) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx moves on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_q ^ PAR_ODD;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Asynchronous serial transmitter, directly downstream of the baud clock divider.
- Consumes the divider's free-running baud square wave and serialises one byte per frame onto the TX line: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Runs entirely in the system clock domain. The baud input is sampled and edge-detected; it is never used as a clock.
- Upstream logic (command/echo path) hands bytes in over a valid/ready handshake.

Parameters:
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even. Any other value behaves as 0.
- STOP_BITS, 1: number of stop bits, 1 or 2. Any other value behaves as 1.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- rst_n  input  1  reset, asynchronous, active-low.
- clk_bps  input  1  baud square wave from the divider, free-running (period 5209 clk at 9600 baud).
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept a byte.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress (accepted, not yet finished).
- tx_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async assert, all regs): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, shift/bit count/parity=0, sync flops=0.
- Baud tick:
  - clk_bps passes through two flops (s1, s2) plus a third history flop (s3).
  - bps_tick = s2 & ~s3: one clk cycle per clk_bps rising edge, 3 clk after that edge.
  - Falling edges are ignored.
- Handshake:
  - Transfer occurs on the clk edge where tx_valid & tx_ready.
  - tx_data is latched into the shift register at that edge.
  - On the next cycle, tx_ready=0 and tx_busy=1.
  - tx_valid while tx_ready=0 is ignored; no queueing.
- States:
  - IDLE: tx=1, ready=1. On transfer, go to ARM.
  - ARM: tx=1. Waits for the next bps_tick so the start bit is baud-aligned. Latency from transfer to start bit is between 3 clk and one baud period + 3 clk. On tick, go to START.
  - START: tx=0 for one tick interval. On tick, go to DATA with bit count=0.
  - DATA: tx=shift[0]. On each tick, shift right and increment bit count. After the tick that ends bit 7 (count 7), go to PAR if PARITY≠0, else STOP.
  - PAR: tx = XOR of the 8 latched bits for even, inverted for odd. On tick, go to STOP.
  - STOP: tx=1 for STOP_BITS tick intervals. On the final tick, tx_done=1 for that single cycle and state goes to IDLE. tx_ready=1 and tx_busy=0 from the following cycle.
- tx is registered. The line changes on the clk edge that samples bps_tick high, i.e. each bit is held exactly one baud period (5209 clk at default).
- Frame length in ticks: 1 + 8 + (PARITY≠0) + STOP_BITS.
- Parity is computed from the latched byte, not from live tx_data.
- Back-to-back frames: a new transfer is accepted the cycle after tx_done. It re-enters ARM, so no glitch-free idle gap is required beyond the wait for the next tick.
- Reset mid-frame: tx returns to 1 immediately (async) and the frame is abandoned. After release, the block is IDLE with ready=1.
- clk_bps stuck (no edges): the block stays in ARM/current bit indefinitely. tx holds its value; no timeout.
- A tick in the same cycle as a transfer (IDLE) does not start the frame; the first usable tick is the next one.

Test Plan:
- Reset, then tx_data=0x55, PARITY=0, STOP_BITS=1, pulse tx_valid. Expect tx: 0,1,0,1,0,1,0,1,0 then stop 1; each bit 5209 clk; tx_done one pulse after 10 tick intervals; ready back high the next cycle.
- PARITY=2 with 0x03: parity bit 0. PARITY=1 with 0x03: parity bit 1. PARITY=2 with 0x07: parity bit 1. Frames are 11 bits.
- STOP_BITS=2 with 0xA5: data bits 1,0,1,0,0,1,0,1, then tx high for 2 tick intervals before tx_done.
- tx_valid held high with 0x12 then 0x34 changing mid-frame. Expect only 0x12 sent; 0x34 is accepted only after tx_done, and the second frame decodes as 0x34.
- Assert rst_n low during data bit 4. Expect tx=1, ready=1, busy=0 immediately; a subsequent 0xFF frame transmits cleanly.
- Stop clk_bps toggling in ARM for 20000 clk. Expect tx=1, busy=1, no tx_done; resuming clk_bps produces a correct frame.
